// File: rtl/fetch_port_arbiter.sv
// Shares one instruction-memory port among NUM_WAYS fetch ways: round-robin grant,
// one outstanding access, per-way response routing, jump squashing and a watchdog.
module fetch_port_arbiter #(
    parameter int unsigned NUM_WAYS   = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_WAYS-1:0]            way_request_i,
    input  logic [NUM_WAYS*ADDR_WIDTH-1:0] way_instAddr_i,
    input  logic                           jumpFlag_i,
    output logic [NUM_WAYS*INST_WIDTH-1:0] way_inst_o,
    output logic [NUM_WAYS-1:0]            way_dataOk_o,
    output logic                           mem_request_o,
    output logic [ADDR_WIDTH-1:0]          mem_instAddr_o,
    input  logic [INST_WIDTH-1:0]          mem_inst_i,
    input  logic                           mem_dataOk_i,
    output logic                           busy_o,
    output logic                           timeout_err_o
);

    localparam int unsigned GRANT_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          WD_EN   = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        DROP = 2'd3
    } arbStateT;

    arbStateT              state;
    logic [GRANT_W-1:0]    lastGrant;
    logic [GRANT_W-1:0]    grantIdx;
    logic [WD_W-1:0]       wdCount;

    logic [GRANT_W-1:0]    scanIdx;
    logic                  scanHit;
    logic [ADDR_WIDTH-1:0] scanAddr;
    int unsigned           cand;

    // Round-robin scan starting just after the previous winner.
    always_comb begin
        scanIdx = lastGrant;
        scanHit = 1'b0;
        cand    = 0;
        for (int unsigned i = 1; i <= NUM_WAYS; i++) begin
            cand = 32'(lastGrant) + i;
            if (cand >= NUM_WAYS) begin
                cand = cand - NUM_WAYS;
            end
            if (!scanHit && way_request_i[GRANT_W'(cand)]) begin
                scanHit = 1'b1;
                scanIdx = GRANT_W'(cand);
            end
        end
    end

    always_comb begin
        scanAddr = '0;
        for (int unsigned k = 0; k < NUM_WAYS; k++) begin
            if (GRANT_W'(k) == scanIdx) begin
                scanAddr = way_instAddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            lastGrant      <= GRANT_W'(NUM_WAYS - 1);
            grantIdx       <= '0;
            wdCount        <= '0;
            way_inst_o     <= '0;
            way_dataOk_o   <= '0;
            mem_request_o  <= 1'b0;
            mem_instAddr_o <= '0;
            busy_o         <= 1'b0;
            timeout_err_o  <= 1'b0;
        end else begin
            way_dataOk_o <= '0;
            case (state)
                IDLE: begin
                    if (!jumpFlag_i && scanHit) begin
                        grantIdx       <= scanIdx;
                        lastGrant      <= scanIdx;
                        mem_instAddr_o <= scanAddr;
                        mem_request_o  <= 1'b1;
                        busy_o         <= 1'b1;
                        wdCount        <= '0;
                        state          <= BUSY;
                    end
                end
                BUSY, DROP: begin
                    if (mem_dataOk_i) begin
                        mem_request_o <= 1'b0;
                        if (state == BUSY && !jumpFlag_i) begin
                            for (int unsigned k = 0; k < NUM_WAYS; k++) begin
                                if (GRANT_W'(k) == grantIdx) begin
                                    way_inst_o[k*INST_WIDTH +: INST_WIDTH] <= mem_inst_i;
                                    way_dataOk_o[k]                        <= 1'b1;
                                end
                            end
                            state <= RESP;
                        end else begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (WD_EN && wdCount == WD_LAST) begin
                        // Memory never answered: abandon the access without a response.
                        timeout_err_o <= 1'b1;
                        mem_request_o <= 1'b0;
                        busy_o        <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        if (WD_EN) begin
                            wdCount <= wdCount + 1'b1;
                        end
                        if (jumpFlag_i) begin
                            state <= DROP;
                        end
                    end
                end
                RESP: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o        <= 1'b0;
                    mem_request_o <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_port_arbiter.sv
// Bench for fetch_port_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model.
module tb_fetch_port_arbiter;

    localparam int unsigned NUM_WAYS   = 2;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned TIMEOUT    = 8;

    logic                           clk = 1'b0;
    logic                           reset = 1'b1;
    logic [NUM_WAYS-1:0]            way_request_i = '0;
    logic [NUM_WAYS*ADDR_WIDTH-1:0] way_instAddr_i = '0;
    logic                           jumpFlag_i = 1'b0;
    logic [NUM_WAYS*INST_WIDTH-1:0] way_inst_o;
    logic [NUM_WAYS-1:0]            way_dataOk_o;
    logic                           mem_request_o;
    logic [ADDR_WIDTH-1:0]          mem_instAddr_o;
    logic [INST_WIDTH-1:0]          mem_inst_i = '0;
    logic                           mem_dataOk_i = 1'b0;
    logic                           busy_o;
    logic                           timeout_err_o;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: one access record plus a pending response.
    bit          mInFlight;
    bit          mSquashed;
    bit          mErr;
    int          mWay;
    int          mRespWay;
    int          mWait;
    int          mLast;
    logic [31:0] mAddr;
    logic [31:0] mInst [NUM_WAYS];

    always #5 clk = ~clk;

    fetch_port_arbiter #(
        .NUM_WAYS  (NUM_WAYS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .INST_WIDTH(INST_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .way_request_i (way_request_i),
        .way_instAddr_i(way_instAddr_i),
        .jumpFlag_i    (jumpFlag_i),
        .way_inst_o    (way_inst_o),
        .way_dataOk_o  (way_dataOk_o),
        .mem_request_o (mem_request_o),
        .mem_instAddr_o(mem_instAddr_o),
        .mem_inst_i    (mem_inst_i),
        .mem_dataOk_i  (mem_dataOk_i),
        .busy_o        (busy_o),
        .timeout_err_o (timeout_err_o)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep();
        bit found;
        if (reset) begin
            mInFlight = 0; mSquashed = 0; mErr = 0; mWay = 0; mRespWay = -1;
            mWait = 0; mLast = int'(NUM_WAYS) - 1; mAddr = '0;
            for (int k = 0; k < int'(NUM_WAYS); k++) mInst[k] = '0;
            return;
        end
        if (mRespWay >= 0) begin
            mRespWay = -1;
        end else if (mInFlight) begin
            if (mem_dataOk_i) begin
                mInFlight = 0;
                if (!mSquashed && !jumpFlag_i) begin
                    mInst[mWay] = mem_inst_i;
                    mRespWay    = mWay;
                end
            end else if (mWait == int'(TIMEOUT) - 1) begin
                mErr      = 1;
                mInFlight = 0;
            end else begin
                mWait++;
                if (jumpFlag_i) mSquashed = 1;
            end
        end else if (!jumpFlag_i) begin
            found = 0;
            for (int i = 1; i <= int'(NUM_WAYS); i++) begin
                int w;
                w = (mLast + i) % int'(NUM_WAYS);
                if (!found && way_request_i[w]) begin
                    found = 1; mWay = w; mLast = w; mInFlight = 1; mSquashed = 0; mWait = 0;
                    mAddr = way_instAddr_i[w*32 +: 32];
                end
            end
        end
    endtask

    task automatic compareAll();
        logic [NUM_WAYS-1:0]            expOk;
        logic [NUM_WAYS*INST_WIDTH-1:0] expInst;
        expOk = '0;
        if (mRespWay >= 0) expOk[mRespWay] = 1'b1;
        for (int k = 0; k < int'(NUM_WAYS); k++) expInst[k*32 +: 32] = mInst[k];
        checkVal("memReq", mem_request_o, mInFlight);
        checkVal("memAddr", mem_instAddr_o, mAddr);
        checkVal("dataOk", way_dataOk_o, expOk);
        checkVal("wayInst", way_inst_o, expInst);
        checkVal("busy", busy_o, mInFlight || (mRespWay >= 0));
        checkVal("timeoutErr", timeout_err_o, mErr);
    endtask

    // Inputs are applied at the falling edge; the model steps alongside the DUT.
    task automatic tick();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    task automatic doReset();
        reset = 1'b1; way_request_i = '0; jumpFlag_i = 1'b0; mem_dataOk_i = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    int pulseVal [$];
    int pulseCyc [$];
    int hiCount;

    initial begin
        tick();
        doReset();
        checkVal("reset_busy", busy_o, 0);
        checkVal("reset_memReq", mem_request_o, 0);
        checkVal("reset_inst", way_inst_o, 0);

        // Single request from way 0.
        way_request_i = 2'b01; way_instAddr_i[31:0] = 32'h8000_0000;
        tick();
        checkVal("single_req", mem_request_o, 1);
        checkVal("single_addr", mem_instAddr_o, 32'h8000_0000);
        tick(); tick();
        mem_dataOk_i = 1'b1; mem_inst_i = 32'h0010_0093;
        tick();
        checkVal("single_ok", way_dataOk_o, 2'b01);
        checkVal("single_inst", way_inst_o[31:0], 32'h0010_0093);
        mem_dataOk_i = 1'b0; way_request_i = '0;
        tick();
        checkVal("single_pulse_end", way_dataOk_o, 2'b00);

        // Flush coincident with the response.
        way_request_i = 2'b01; way_instAddr_i[31:0] = 32'h8000_0004;
        tick();
        jumpFlag_i = 1'b1; mem_dataOk_i = 1'b1; mem_inst_i = 32'hDEAD_BEEF;
        tick();
        checkVal("coinc_ok", way_dataOk_o, 2'b00);
        checkVal("coinc_busy", busy_o, 0);
        checkVal("coinc_inst", way_inst_o[31:0], 32'h0010_0093);
        jumpFlag_i = 1'b0; mem_dataOk_i = 1'b0; way_request_i = '0;
        tick();

        // Round-robin with single-cycle memory.
        doReset();
        way_request_i = 2'b11;
        way_instAddr_i = {32'h0000_2000, 32'h0000_1000};
        for (int c = 0; c < 14; c++) begin
            mem_dataOk_i = mInFlight; mem_inst_i = 32'h100 + 32'(c);
            tick();
            if (way_dataOk_o != 0) begin
                pulseVal.push_back(int'(way_dataOk_o));
                pulseCyc.push_back(c);
            end
        end
        checkVal("rr_count", pulseVal.size() >= 4, 1);
        if (pulseVal.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checkVal("rr_order", pulseVal[i], (i % 2 == 0) ? 1 : 2);
                if (i > 0) checkVal("rr_gap", pulseCyc[i] - pulseCyc[i-1], 3);
            end
        end
        way_request_i = '0; mem_dataOk_i = 1'b0;
        tick(); tick(); tick();

        // Flush mid-flight.
        doReset();
        way_request_i = 2'b01; way_instAddr_i[31:0] = 32'h0000_3000;
        tick(); tick();
        jumpFlag_i = 1'b1;
        tick();
        checkVal("drop_memReq", mem_request_o, 1);
        tick();
        jumpFlag_i = 1'b0; mem_dataOk_i = 1'b1; mem_inst_i = 32'h5555_AAAA;
        tick();
        checkVal("drop_busy", busy_o, 0);
        checkVal("drop_ok", way_dataOk_o, 2'b00);
        mem_dataOk_i = 1'b0;
        tick();
        checkVal("drop_regrant", mem_request_o, 1);
        mem_dataOk_i = 1'b1; mem_inst_i = 32'h1234_5678;
        tick();
        checkVal("drop_next_ok", way_dataOk_o, 2'b01);
        mem_dataOk_i = 1'b0; way_request_i = '0;
        tick();

        // Watchdog timeout.
        doReset();
        way_request_i = 2'b01; way_instAddr_i[31:0] = 32'h0000_4000;
        tick();
        hiCount = mem_request_o ? 1 : 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_request_o) hiCount++;
            else break;
        end
        checkVal("to_cycles", hiCount, 8);
        checkVal("to_err", timeout_err_o, 1);
        tick();
        checkVal("to_regrant", mem_request_o, 1);
        mem_dataOk_i = 1'b1; mem_inst_i = 32'h0BAD_F00D;
        tick();
        checkVal("to_served", way_dataOk_o, 2'b01);
        checkVal("to_sticky", timeout_err_o, 1);
        mem_dataOk_i = 1'b0; way_request_i = '0;
        tick();

        // Reset mid-operation.
        way_request_i = 2'b11; way_instAddr_i = {32'h0000_6000, 32'h0000_5000};
        tick(); tick();
        reset = 1'b1;
        tick();
        checkVal("rst_memReq", mem_request_o, 0);
        checkVal("rst_err", timeout_err_o, 0);
        checkVal("rst_inst", way_inst_o, 0);
        reset = 1'b0; way_request_i = '0; mem_dataOk_i = 1'b1;
        tick();
        checkVal("rst_late_ok", way_dataOk_o, 2'b00);
        mem_dataOk_i = 1'b0; way_request_i = 2'b11;
        tick();
        checkVal("rst_first_addr", mem_instAddr_o, 32'h0000_5000);
        mem_dataOk_i = 1'b1; mem_inst_i = 32'hCAFE_0001;
        tick();
        checkVal("rst_first_way", way_dataOk_o, 2'b01);
        mem_dataOk_i = 1'b0; way_request_i = '0;
        tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 599) == 0);
            jumpFlag_i   = ($urandom_range(0, 11) == 0);
            mem_dataOk_i = mInFlight ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            mem_inst_i   = $urandom;
            for (int k = 0; k < int'(NUM_WAYS); k++) begin
                if (mRespWay == k) begin
                    way_request_i[k] = 1'b0;
                end else if (!way_request_i[k] && $urandom_range(0, 2) == 0) begin
                    way_request_i[k] = 1'b1;
                    way_instAddr_i[k*32 +: 32] = $urandom;
                end else if (way_request_i[k] && $urandom_range(0, 39) == 0) begin
                    way_request_i[k] = 1'b0;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
